// File: rtl/input_debouncer.sv
// Synchronises a bouncy external input into the clk domain and qualifies level changes
// over DEBOUNCE_CYCLES consecutive samples, producing a clean q plus rise/fall pulses.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_reg [SYNC_STAGES];
    logic             s;
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             q_reg, q_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             busy_reg, busy_next;

    // Only the last synchroniser stage is ever observed by the qualifier.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= din;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            IDLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg >= CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg >= CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        q_next    = (state_next == IDLE_HIGH) || (state_next == WAIT_LOW);
        busy_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE_LOW;
            cnt_reg   <= '0;
            q_reg     <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            busy_reg  <= busy_next;
        end
    end

    assign q    = q_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;
    assign busy = busy_reg;

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditioning stage that sits directly upstream of the D flip-flop primitive. It takes an asynchronous, bouncy external input (push-button or switch) and synchronises it into the clk domain. It filters bounce and drives a clean, stable level on the flip-flop's d input. It also provides one-cycle rise/fall pulses for downstream control logic.

Parameters:
SYNC_STAGES, 2, number of synchroniser flip-flops in series on din (legal range 2..4).
DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a new level (legal range 2..2^CNT_W-1).
CNT_W, 8, width of the internal debounce counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  1  raw asynchronous input, may bounce or glitch.
q  output  1  debounced, registered level (feeds the D flip-flop d input).
rise  output  1  one-cycle pulse when q goes 0->1.
fall  output  1  one-cycle pulse when q goes 1->0.
busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset (asynchronous, active-high):
  - Applies immediately, independent of clk.
  - Synchroniser chain = 0, counter = 0, state = IDLE_LOW.
  - Outputs: q=0, rise=0, fall=0, busy=0.
  - Held for as long as rst=1.
- Synchroniser:
  - din shifts through SYNC_STAGES flops.
  - The last stage, "s", is the only signal the FSM observes.
  - din is never used combinationally.
- FSM states: IDLE_LOW (q=0), WAIT_HIGH (q=0, busy=1), IDLE_HIGH (q=1), WAIT_LOW (q=1, busy=1).
- Transitions, evaluated every rising edge:
  - IDLE_LOW, s=1 -> WAIT_HIGH, cnt=1. IDLE_LOW, s=0 -> stay, cnt=0.
  - WAIT_HIGH, s=0 -> IDLE_LOW, cnt=0. No output change.
  - WAIT_HIGH, s=1, cnt==DEBOUNCE_CYCLES-1 -> IDLE_HIGH, q=1, rise=1 for exactly one cycle, cnt=0.
  - WAIT_HIGH, s=1, cnt<DEBOUNCE_CYCLES-1 -> stay, cnt+1.
  - IDLE_HIGH, WAIT_LOW: mirror image of the above, with s=0 as the candidate level and fall pulsed on acceptance.
- Latency:
  - din change (setup met before edge E1) -> q change registered at edge E(SYNC_STAGES+DEBOUNCE_CYCLES).
  - With defaults, q changes on the 6th rising edge.
  - rise/fall assert on the same edge q changes and deassert on the next edge.
- Outputs:
  - All outputs are registered; no combinational path from din.
  - rise and fall are never high simultaneously.
  - rise/fall never assert without a q change.
- Glitch rejection:
  - Any s pulse shorter than DEBOUNCE_CYCLES samples returns the FSM to its IDLE state.
  - No q change, no pulse; busy drops on the edge the FSM returns to IDLE.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1.
  - Never wraps, regardless of how long the input is held.
- Reset mid-qualification (busy=1):
  - Aborts immediately; no pulse emitted.
- Reset while q=1:
  - q drops to 0 asynchronously; fall is NOT pulsed.
  - After release with din held high, q rises again after SYNC_STAGES+DEBOUNCE_CYCLES edges, with rise pulsed.
- Level held steady: no pulses, busy=0 indefinitely.

Test Plan:
1. Reset check:
   - Stimulus: rst=1 for 15 ns, din toggling.
   - Required response: q=rise=fall=busy=0 throughout, including before the first clk edge.
2. Clean rise:
   - Stimulus: clk period 10 ns, defaults, rst released, din=0->1 between edges.
   - Required response: busy=1 from edge 3; q=1 and rise=1 at edge 6; rise=0 at edge 7; busy=0 from edge 6.
3. Bounce rejection:
   - Stimulus: din high for 2 cycles, low 1, high 2, low thereafter.
   - Required response: q stays 0; rise never asserts; busy returns to 0.
4. Clean fall:
   - Stimulus: from q=1, din=1->0.
   - Required response: q=0 and fall=1 at edge 6 after the change; fall lasts exactly one cycle.
5. Reset mid-operation:
   - Stimulus: din=1 held; rst pulsed 3 ns mid-cycle while busy=1; then a second rst pulse after q=1.
   - Required response: q forced to 0 immediately each time; no fall pulse; q re-rises at edge 6 after each release.
6. Parameter sweep:
   - Stimulus: SYNC_STAGES=3, DEBOUNCE_CYCLES=10, input held 9 samples then 10 samples.
   - Required response: 9 samples are rejected; 10 samples are accepted at edge 13.
